// File: rtl/urv_console_tx_if.sv
// CPU data-port bundle for the console transmitter.
// Handshake: store/load are levels held by the CPU until the matching one-cycle
// done pulse; a still-held request is only recognised again after that done cycle.
interface urv_console_tx_if;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i;
    logic        dm_load_i;
    logic [31:0] dm_data_l_o;
    logic        dm_store_done_o;
    logic        dm_load_done_o;

    modport master (
        output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
        input  dm_data_l_o, dm_store_done_o, dm_load_done_o
    );

    modport slave (
        input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
        output dm_data_l_o, dm_store_done_o, dm_load_done_o
    );
endinterface

// File: rtl/urv_console_tx.sv
// Memory-mapped console UART transmitter: data/status registers, byte FIFO
// and an 8N1 serialiser with a registered txd output.
module urv_console_tx #(
    parameter logic [31:0] g_base_addr  = 32'h0010_0000,
    parameter int          g_clk_div    = 16,
    parameter int          g_fifo_depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    urv_console_tx_if.slave  dm,
    output logic             txd_o,
    output logic [1:0]       o_fsm_state
);
    localparam int              c_aw        = $clog2(g_fifo_depth);
    localparam logic [31:0]     c_stat_addr = g_base_addr + 32'd4;
    localparam logic [15:0]     c_div_m1    = 16'(g_clk_div - 1);
    localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(g_fifo_depth);
    localparam logic [c_aw:0]   c_cnt_one   = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t          r_state;
    logic [15:0]     r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_txd;
    logic [7:0]      r_mem [g_fifo_depth];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            r_store_done;
    logic            r_load_done;
    logic [31:0]     r_load_data;

    logic        w_sel_data;
    logic        w_sel_stat;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_st_acc;
    logic        w_ld_acc;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_sel_data = (dm.dm_addr_i[31:2] == g_base_addr[31:2]);
    assign w_sel_stat = (dm.dm_addr_i[31:2] == c_stat_addr[31:2]);
    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_status   = {15'd0, 9'(r_count), 5'd0, w_empty, w_full, w_busy};

    // The done register blocks re-acceptance of a request still held during its done cycle.
    assign w_st_acc = dm.dm_store_i && !r_store_done &&
                      (w_sel_stat || (w_sel_data && (!dm.dm_data_select_i[0] || !w_full)));
    assign w_ld_acc = dm.dm_load_i && !r_load_done && (w_sel_stat || w_sel_data);
    assign w_push   = w_st_acc && w_sel_data && dm.dm_data_select_i[0];
    assign w_pop    = (r_state == ST_IDLE) && !w_empty;

    assign w_unused = &{1'b0, dm.dm_addr_i[1:0], dm.dm_data_s_i[31:8], dm.dm_data_select_i[3:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_store_done <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_store_done <= w_st_acc;
            r_load_done  <= w_ld_acc;
            if (w_ld_acc) begin
                r_load_data <= w_sel_stat ? w_status : 32'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dm.dm_data_s_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // txd follows the state registered one cycle earlier, so each bit lags its state by one clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_timer <= c_div_m1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_txd <= 1'b0;
                    if (r_timer == '0) begin
                        r_timer   <= c_div_m1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    r_txd <= r_shift[r_bit_idx];
                    if (r_timer == '0) begin
                        r_timer <= c_div_m1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                    r_txd <= 1'b1;
                    if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
            endcase
        end
    end

    assign txd_o              = r_txd;
    assign o_fsm_state        = r_state;
    assign dm.dm_data_l_o     = r_load_data;
    assign dm.dm_store_done_o = r_store_done;
    assign dm.dm_load_done_o  = r_load_done;
endmodule

// File: tb/tb_urv_console_tx.sv
// Directed self-checking bench for urv_console_tx (clk_div 4, FIFO depth 4).
module tb_urv_console_tx;
    localparam logic [31:0] c_data_addr = 32'h0010_0000;
    localparam logic [31:0] c_stat_addr = 32'h0010_0004;
    localparam logic [31:0] c_bad_addr  = 32'h0010_0008;

    logic       clk = 1'b0;
    logic       rst;
    logic       txd;
    logic [1:0] fsm_state;

    urv_console_tx_if bus();

    urv_console_tx #(
        .g_base_addr (32'h0010_0000),
        .g_clk_div   (4),
        .g_fifo_depth(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .dm         (bus.slave),
        .txd_o      (txd),
        .o_fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks are entered on a negedge and return on a negedge.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                            input int max_cyc, output int lat, output bit done);
        bus.dm_addr_i        = addr;
        bus.dm_data_s_i      = data;
        bus.dm_data_select_i = sel;
        bus.dm_store_i       = 1'b1;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < max_cyc) begin
            @(negedge clk);
            lat++;
            done = bus.dm_store_done_o;
        end
        bus.dm_store_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input int max_cyc,
                           output logic [31:0] data, output int lat, output bit done);
        bus.dm_addr_i = addr;
        bus.dm_load_i = 1'b1;
        lat  = 0;
        done = 1'b0;
        data = '0;
        while (!done && lat < max_cyc) begin
            @(negedge clk);
            lat++;
            done = bus.dm_load_done_o;
            data = bus.dm_data_l_o;
        end
        bus.dm_load_i = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (txd !== 1'b0 && n < 400);
        ok = (txd === 1'b0);
    endtask

    task automatic rx_frame(output logic [7:0] b, output bit ok);
        bit st;
        b = '0;
        wait_start(st);
        repeat (2) @(negedge clk);
        ok = st && (txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = txd;
        end
        repeat (4) @(negedge clk);
        ok = ok && (txd === 1'b1);
    endtask

    task automatic count_lows(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          idx;
        int          lows;
        bit          dn;
        bit          ok;
        logic [31:0] rd;
        logic [39:0] wave;
        logic [39:0] exp_wave;
        logic [7:0]  b55;
        logic [7:0]  tx_bytes [6];
        logic [7:0]  rx_bytes [6];
        bit          rx_ok    [6];
        int          st_lat   [6];
        bit          st_dn    [6];

        rst                  = 1'b1;
        bus.dm_addr_i        = '0;
        bus.dm_data_s_i      = '0;
        bus.dm_data_select_i = '0;
        bus.dm_store_i       = 1'b0;
        bus.dm_load_i        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_store_done", bus.dm_store_done_o, 0);
        check("rst_load_done", bus.dm_load_done_o, 0);
        check("rst_load_data", bus.dm_data_l_o, 0);
        rst = 1'b0;
        @(negedge clk);

        do_load(c_stat_addr, 20, rd, lat, dn);
        check("idle_status", rd, 32'h0000_0004);
        check("idle_status_lat", lat, 1);
        do_load(c_data_addr, 20, rd, lat, dn);
        check("data_reg_load", rd, 32'h0000_0000);

        // Single 0x55 frame compared cycle by cycle.
        b55 = 8'h55;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       exp_wave[i] = 1'b0;
            else if (i < 36) exp_wave[i] = b55[(i - 4) / 4];
            else             exp_wave[i] = 1'b1;
        end
        do_store(c_data_addr, 32'h0000_0055, 4'h1, 20, lat, dn);
        check("st55_lat", lat, 1);
        wait_start(ok);
        check("st55_start", ok, 1);
        wave[0] = txd;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            wave[i] = txd;
        end
        check("st55_wave", wave, exp_wave);
        @(negedge clk);
        do_load(c_stat_addr, 20, rd, lat, dn);
        check("st55_status_after", rd, 32'h0000_0004);

        // Byte lane 0 disabled: completes but queues nothing.
        do_store(c_data_addr, 32'h0000_00AA, 4'b0010, 20, lat, dn);
        check("sel0_off_lat", lat, 1);
        do_load(c_stat_addr, 20, rd, lat, dn);
        check("sel0_off_status", rd, 32'h0000_0004);
        count_lows(30, lows);
        check("sel0_off_txd_lows", lows, 0);

        // Undecoded address: no done pulses, no state change.
        do_store(c_bad_addr, 32'h0000_0033, 4'h1, 10, lat, dn);
        check("bad_store_done", dn, 0);
        do_load(c_bad_addr, 10, rd, lat, dn);
        check("bad_load_done", dn, 0);
        @(negedge clk);
        do_load(c_stat_addr, 20, rd, lat, dn);
        check("bad_status", rd, 32'h0000_0004);
        count_lows(20, lows);
        check("bad_txd_lows", lows, 0);

        // Six back-to-back stores into a depth-4 FIFO; the sixth must stall.
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'h01;
        tx_bytes[3] = 8'h80; tx_bytes[4] = 8'hF0; tx_bytes[5] = 8'h5A;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    do_store(c_data_addr, {24'd0, tx_bytes[k]}, 4'h1, 300, st_lat[k], st_dn[k]);
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    rx_frame(rx_bytes[k], rx_ok[k]);
                end
            end
        join
        for (int k = 0; k < 5; k++) begin
            check($sformatf("burst_lat%0d", k), (st_dn[k] && st_lat[k] <= 2), 1);
        end
        check("burst_lat5_stalled", (st_dn[5] && st_lat[5] >= 20), 1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("burst_rx%0d", k), {rx_ok[k], rx_bytes[k]}, {1'b1, tx_bytes[k]});
        end
        repeat (8) @(negedge clk);
        do_load(c_stat_addr, 20, rd, lat, dn);
        check("burst_status_after", rd, 32'h0000_0004);

        // Busy status with two queued, then reset in the middle of bit 3.
        do_store(c_data_addr, 32'h0000_0000, 4'h1, 20, lat, dn);
        check("rs_st0_lat", lat, 1);
        wait_start(ok);
        check("rs_start", ok, 1);
        idx = 0;
        do_store(c_data_addr, 32'h0000_0011, 4'h1, 20, lat, dn);
        idx += lat;
        do_store(c_data_addr, 32'h0000_0022, 4'h1, 20, lat, dn);
        idx += lat;
        do_load(c_stat_addr, 20, rd, lat, dn);
        idx += lat;
        check("busy_status", rd, 32'h0000_0201);
        repeat (18 - idx) @(negedge clk);
        check("pre_rst_bit3", txd, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", txd, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_load(c_stat_addr, 20, rd, lat, dn);
        check("rst_mid_status", rd, 32'h0000_0004);
        count_lows(200, lows);
        check("rst_mid_no_frames", lows, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/urv_console_tx.md
URV_CONSOLE_TX -- requirements
Module: urv_console_tx

Interface
REQ-001 Parameter g_base_addr, default 32'h0010_0000: byte address of the TX data register. The status register is at g_base_addr+4.
REQ-002 Parameter g_clk_div, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-003 Parameter g_fifo_depth, default 16: TX FIFO entries; must be a power of 2 in the range 2..256.
REQ-004 clk_i  in  1  single clock; all logic is rising-edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 dm_addr_i  in  32  CPU data-port byte address.
REQ-007 dm_data_s_i  in  32  CPU store data.
REQ-008 dm_data_select_i  in  4  store byte enables.
REQ-009 dm_store_i  in  1  store request, level, held until done.
REQ-010 dm_load_i  in  1  load request, level, held until done.
REQ-011 dm_data_l_o  out  32  load data, registered.
REQ-012 dm_store_done_o  out  1  one-cycle store-complete pulse.
REQ-013 dm_load_done_o  out  1  one-cycle load-complete pulse.
REQ-014 txd_o  out  1  serial output, idle high.

Function
REQ-015 The block SHALL decode only dm_addr_i[31:2]. Accesses to addresses other than the data and status registers SHALL produce no done pulse and no side effect.
REQ-016 A store to the data register with dm_data_select_i[0]=1 SHALL push dm_data_s_i[7:0] when the FIFO is not full. dm_store_done_o SHALL pulse on the following cycle.
REQ-017 A data-register store issued while the FIFO is full SHALL be held with no done pulse. It SHALL be accepted on the first cycle the registered count is below g_fifo_depth.
REQ-018 A data-register store with dm_data_select_i[0]=0 SHALL push nothing and SHALL still complete one cycle later.
REQ-019 A store request still held in the cycle its done pulse is asserted SHALL NOT be accepted a second time. A new request is recognised only after a cycle with done high.
REQ-020 Stores to the status register SHALL be ignored and SHALL complete one cycle later.
REQ-021 A load from the status register SHALL return the following fields: bit0 tx_busy (FSM not IDLE), bit1 fifo_full, bit2 fifo_empty, bits[16:8] fifo count, all other bits 0. The value is sampled in the request cycle; dm_data_l_o and dm_load_done_o SHALL be valid one cycle later.
REQ-022 A load from the data register SHALL return 0 with the same 1-cycle latency.
REQ-023 The FIFO SHALL be first-in first-out with wrapping read/write pointers and a count of log2(g_fifo_depth)+1 bits.
REQ-024 A push and a pop in the same cycle SHALL leave the count unchanged. A push while full SHALL be impossible per REQ-017, and a pop while empty SHALL never occur.
REQ-025 The TX FSM SHALL have four states:
- IDLE: txd_o=1. Pops when the FIFO is non-empty and moves to START.
- START: txd_o=0 for g_clk_div cycles.
- DATA: 8 bits, LSB first, each held for g_clk_div cycles.
- STOP: txd_o=1 for g_clk_div cycles, then IDLE.
REQ-026 The bit timer SHALL count g_clk_div-1 down to 0. The state or bit index SHALL advance on 0.
REQ-027 On leaving STOP with the FIFO non-empty, the FSM SHALL enter IDLE for exactly one cycle and pop there, giving an inter-frame gap of 1 cycle.
REQ-028 txd_o SHALL be a registered output, delaying each bit boundary by 1 cycle from its FSM state change.
REQ-029 Frame length SHALL be 10*g_clk_div cycles.

Reset
REQ-030 While rst_i=1 the block SHALL hold: FIFO empty, pointers 0, FSM IDLE, timer 0, txd_o=1, dm_data_l_o=0, both done outputs 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame and drive txd_o=1 on the next cycle. All queued bytes SHALL be discarded.
REQ-032 A request pending during reset SHALL be ignored. The CPU re-issues it after reset.

Verification
REQ-033 g_clk_div=4: store 0x55 to 0x100000.
- Required response: store_done one cycle later.
- txd_o low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; 40 cycles total.
REQ-034 g_fifo_depth=4, g_clk_div=4: store 6 bytes back to back.
- Required response: 5 accepted immediately (1 popped into the FSM, 4 queued); the 6th stalls until the first frame ends.
- Bytes appear on txd_o in order.
REQ-035 Load 0x100004 while idle and empty.
- Required response: 0x0000_0004.
- After 3 stores while busy (first byte popped), the load returns 0x0000_0201.
REQ-036 Store with dm_data_select_i=4'b0010 to 0x100000.
- Required response: done pulse only, FIFO unchanged, txd_o stays high.
REQ-037 Reset asserted during bit 3 of a frame with 2 bytes queued.
- Required response: txd_o=1 the next cycle.
- Status reads 0x0000_0004 after reset.
- No further frames are sent.
REQ-038 Store and load to 0x100008.
- Required response: no done pulses, FIFO unchanged.
